// File: rtl/imem_boot_loader.sv
// Boot-time instruction memory loader: accepts 32-bit words on a valid/ready
// stream, writes each as four little-endian byte writes, then releases the core.
module imem_boot_loader #(
    parameter int MEM_BYTES = 256,
    parameter int ADDR_W    = 32,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    input  logic              in_last,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    output logic              core_hold,
    output logic              done,
    output logic              truncated,
    output logic [CNT_W-1:0]  word_count
);

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    // Base address of the final word slot; reaching it without in_last truncates.
    localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'(MEM_BYTES - 4);

    state_t            state, state_next;
    logic [ADDR_W-1:0] base;
    logic [1:0]        byte_idx;
    logic [31:0]       word_q;
    logic              last_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            base       <= '0;
            byte_idx   <= '0;
            word_q     <= '0;
            last_q     <= 1'b0;
            word_count <= '0;
            truncated  <= 1'b0;
            done       <= 1'b0;
            core_hold  <= 1'b1;
        end else begin
            state     <= state_next;
            done      <= (state_next == DONE);
            core_hold <= (state_next != DONE);
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        base       <= '0;
                        word_count <= '0;
                        truncated  <= 1'b0;
                    end
                end
                RECV: begin
                    if (in_valid) begin
                        word_q   <= in_data;
                        last_q   <= in_last;
                        byte_idx <= '0;
                    end
                end
                WRITE: begin
                    byte_idx <= byte_idx + 2'd1;
                    if (byte_idx == 2'd3) begin
                        base       <= base + ADDR_W'(4);
                        word_count <= word_count + CNT_W'(1);
                        if (!last_q && base == LAST_BASE)
                            truncated <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start) state_next = RECV;
            RECV:  if (in_valid) state_next = WRITE;
            WRITE: begin
                if (byte_idx == 2'd3) begin
                    if (last_q || base == LAST_BASE) state_next = DONE;
                    else                             state_next = RECV;
                end
            end
            DONE:  if (start) state_next = RECV;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == RECV);
        mem_we    = (state == WRITE);
        mem_addr  = fetch_addr;
        mem_wdata = word_q[7:0];
        if (state == WRITE)
            mem_addr = base + {{(ADDR_W-2){1'b0}}, byte_idx};
        case (byte_idx)
            2'd0: mem_wdata = word_q[7:0];
            2'd1: mem_wdata = word_q[15:8];
            2'd2: mem_wdata = word_q[23:16];
            2'd3: mem_wdata = word_q[31:24];
            default: mem_wdata = word_q[7:0];
        endcase
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: a default-size instance and a 16-byte
// instance share stimulus; each is held in reset while the other is exercised.
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        reset_a, reset_b;
    logic        start, in_valid, in_last;
    logic [31:0] in_data, fetch_addr;

    logic        a_in_ready, a_mem_we, a_core_hold, a_done, a_truncated;
    logic [31:0] a_mem_addr;
    logic [7:0]  a_mem_wdata, a_word_count;
    logic        b_in_ready, b_mem_we, b_core_hold, b_done, b_truncated;
    logic [31:0] b_mem_addr;
    logic [7:0]  b_mem_wdata, b_word_count;

    logic        sel;
    logic        in_ready, mem_we, core_hold, done, truncated;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata, word_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    imem_boot_loader dut_a (
        .clk(clk), .reset(reset_a), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_last(in_last), .in_ready(a_in_ready),
        .fetch_addr(fetch_addr), .mem_addr(a_mem_addr), .mem_we(a_mem_we),
        .mem_wdata(a_mem_wdata), .core_hold(a_core_hold), .done(a_done),
        .truncated(a_truncated), .word_count(a_word_count)
    );

    imem_boot_loader #(.MEM_BYTES(16)) dut_b (
        .clk(clk), .reset(reset_b), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_last(in_last), .in_ready(b_in_ready),
        .fetch_addr(fetch_addr), .mem_addr(b_mem_addr), .mem_we(b_mem_we),
        .mem_wdata(b_mem_wdata), .core_hold(b_core_hold), .done(b_done),
        .truncated(b_truncated), .word_count(b_word_count)
    );

    always_comb begin
        in_ready   = sel ? b_in_ready   : a_in_ready;
        mem_we     = sel ? b_mem_we     : a_mem_we;
        core_hold  = sel ? b_core_hold  : a_core_hold;
        done       = sel ? b_done       : a_done;
        truncated  = sel ? b_truncated  : a_truncated;
        mem_addr   = sel ? b_mem_addr   : a_mem_addr;
        mem_wdata  = sel ? b_mem_wdata  : a_mem_wdata;
        word_count = sel ? b_word_count : a_word_count;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Handshake one word, then check the four byte writes; optionally pulse
    // start during the second byte write.
    task automatic send_word(input logic [31:0] data, input logic last,
                             input logic [31:0] base, input logic start_mid);
        logic [31:0] w;
        w = data;
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        check("accept_ready", {31'b0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("wr_we",   {31'b0, mem_we}, 32'd1);
            check("wr_addr", mem_addr, base + k);
            check("wr_data", {24'b0, mem_wdata}, {24'b0, w[8*k +: 8]});
            check("wr_hold", {31'b0, core_hold}, 32'd1);
            check("wr_rdy",  {31'b0, in_ready}, 32'd0);
            start = start_mid && (k == 1);
            step();
            start = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        sel = 1'b0;
        reset_a = 1'b1; reset_b = 1'b1;
        start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_data = '0; fetch_addr = 32'h40;
        step(); step();

        // Reset state
        check("rst_done",  {31'b0, done},      32'd0);
        check("rst_hold",  {31'b0, core_hold}, 32'd1);
        check("rst_we",    {31'b0, mem_we},    32'd0);
        check("rst_ready", {31'b0, in_ready},  32'd0);
        check("rst_wc",    {24'b0, word_count}, 32'd0);
        check("rst_trunc", {31'b0, truncated}, 32'd0);
        check("rst_addr",  mem_addr, 32'h40);

        // Two-word program, second word last
        reset_a = 1'b0;
        step();
        check("idle_ready", {31'b0, in_ready}, 32'd0);
        pulse_start();
        check("recv_ready", {31'b0, in_ready}, 32'd1);
        send_word(32'h00500093, 1'b0, 32'd0, 1'b0);
        check("w1_ready", {31'b0, in_ready}, 32'd1);
        check("w1_wc",    {24'b0, word_count}, 32'd1);
        check("w1_done",  {31'b0, done}, 32'd0);
        send_word(32'h00A00113, 1'b1, 32'd4, 1'b0);
        check("p1_done",  {31'b0, done},       32'd1);
        check("p1_hold",  {31'b0, core_hold},  32'd0);
        check("p1_wc",    {24'b0, word_count}, 32'd2);
        check("p1_trunc", {31'b0, truncated},  32'd0);

        // Fetch pass-through after load
        fetch_addr = 32'd4;
        #1;
        check("fetch_addr", mem_addr, 32'd4);
        check("fetch_we",   {31'b0, mem_we}, 32'd0);

        // DONE ignores in_valid
        in_valid = 1'b1; in_data = 32'h12345678; in_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("done_ready", {31'b0, in_ready}, 32'd0);
            check("done_we",    {31'b0, mem_we},   32'd0);
            step();
        end
        in_valid = 1'b0;
        check("done_wc", {24'b0, word_count}, 32'd2);

        // Reload from DONE, start pulsed during WRITE is ignored
        pulse_start();
        check("rl_done",  {31'b0, done},       32'd0);
        check("rl_hold",  {31'b0, core_hold},  32'd1);
        check("rl_wc",    {24'b0, word_count}, 32'd0);
        send_word(32'hDEADBEEF, 1'b1, 32'd0, 1'b1);
        check("rl_wc1",   {24'b0, word_count}, 32'd1);
        check("rl_done1", {31'b0, done},       32'd1);
        check("rl_hold1", {31'b0, core_hold},  32'd0);

        // Reset asserted at WRITE byte 1
        pulse_start();
        in_valid = 1'b1; in_data = 32'h11223344; in_last = 1'b0;
        step();
        in_valid = 1'b0;
        check("mr_b0", {24'b0, mem_wdata}, 32'h44);
        step();
        check("mr_we1", {31'b0, mem_we}, 32'd1);
        check("mr_b1",  {24'b0, mem_wdata}, 32'h33);
        reset_a = 1'b1;
        step();
        reset_a = 1'b0;
        check("mr_we",    {31'b0, mem_we},     32'd0);
        check("mr_hold",  {31'b0, core_hold},  32'd1);
        check("mr_wc",    {24'b0, word_count}, 32'd0);
        check("mr_ready", {31'b0, in_ready},   32'd0);
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("mr_idle_we",  {31'b0, mem_we},   32'd0);
            check("mr_idle_rdy", {31'b0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;

        // 16-byte instance: capacity reached without last
        reset_a = 1'b1;
        sel = 1'b1;
        reset_b = 1'b0;
        step();
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            send_word(32'hA0B0C000 + i, 1'b0, 32'(4 * i), 1'b0);
            if (i < 3) check("cap_ready", {31'b0, in_ready}, 32'd1);
        end
        check("cap_done",  {31'b0, done},       32'd1);
        check("cap_trunc", {31'b0, truncated},  32'd1);
        check("cap_wc",    {24'b0, word_count}, 32'd4);
        in_valid = 1'b1; in_last = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("cap_5th_ready", {31'b0, in_ready}, 32'd0);
            check("cap_5th_we",    {31'b0, mem_we},   32'd0);
            step();
        end
        in_valid = 1'b0;
        check("cap_wc_hold", {24'b0, word_count}, 32'd4);

        // Capacity and last together: not truncated
        pulse_start();
        check("cl_trunc_clr", {31'b0, truncated}, 32'd0);
        for (int i = 0; i < 4; i++)
            send_word(32'h01020304 + i, (i == 3), 32'(4 * i), 1'b0);
        check("cl_done",  {31'b0, done},       32'd1);
        check("cl_trunc", {31'b0, truncated},  32'd0);
        check("cl_wc",    {24'b0, word_count}, 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Boot-time sequencer for the byte-addressed, little-endian instruction memory (256 bytes by default).
- Accepts 32-bit instruction words on a valid/ready stream and writes each word as four byte writes.
- Holds the core stalled while loading, then releases it.
- Owns the memory address mux: the loader drives the address while writing; the fetch PC drives it otherwise.

Parameters:
- MEM_BYTES, 256, instruction memory capacity in bytes; multiple of 4.
- ADDR_W, 32, width of the fetch and memory byte address.
- CNT_W, 8, width of word_count; must satisfy 2^CNT_W > MEM_BYTES/4.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a load.
- in_valid  in  1  word on in_data is valid.
- in_data  in  32  instruction word.
- in_last  in  1  qualifies in_data as the final word of the program.
- in_ready  out  1  loader accepts a word this cycle.
- fetch_addr  in  ADDR_W  core PC byte address.
- mem_addr  out  ADDR_W  byte address to the instruction memory.
- mem_we  out  1  byte write enable.
- mem_wdata  out  8  byte write data.
- core_hold  out  1  stall/hold for the core pipeline.
- done  out  1  load complete; program resident.
- truncated  out  1  sticky; capacity reached before in_last.
- word_count  out  CNT_W  words written in the current or last load.

Behaviour:
- States:
  - IDLE: after reset; waiting for the first start.
  - RECV: waiting for a word.
  - WRITE: four cycles, byte index 0..3.
  - DONE: program resident; core released.
- Reset (synchronous, overrides everything, including mid-WRITE):
  - state=IDLE; base address=0; byte index=0; word_count=0.
  - truncated=0; done=0; core_hold=1; mem_we=0; in_ready=0.
  - A partial word is abandoned and no further bytes are written.
- IDLE: core_hold=1, in_ready=0. start -> RECV; clear base, word_count and truncated.
- RECV:
  - in_ready=1, core_hold=1.
  - When in_valid&&in_ready: latch in_data and in_last, then enter WRITE at byte 0 in the next cycle.
  - start in RECV is ignored.
- WRITE, byte index k:
  - mem_we=1, mem_addr=base+k, mem_wdata=word[8k+7:8k]. This is little-endian, so byte 0 is the LSB at the lowest address.
  - in_ready=0. start is ignored.
  - After k=3: base+=4 and word_count+=1 (both registered).
  - Exit after k=3:
    - If latched last=1 -> DONE.
    - Else if base+4==MEM_BYTES -> DONE with truncated=1.
    - Else -> RECV.
  - Last word and capacity reached together -> DONE with truncated=0.
- DONE:
  - done=1, core_hold=0, in_ready=0. in_valid is ignored and no words are accepted.
  - start -> RECV: clear base, word_count and truncated; done=0 and core_hold=1 from the next cycle.
- Address mux: mem_addr=base+k when in WRITE, else mem_addr=fetch_addr (combinational pass-through).
- mem_we is 0 in every state except WRITE.
- Timing:
  - Throughput is one word per 5 cycles (1 RECV handshake + 4 writes).
  - A word accepted at cycle N is written in cycles N+1..N+4.
  - done rises at N+5 when it is the last word.
- word_count saturates by construction at MEM_BYTES/4. base never wraps past MEM_BYTES.
- core_hold is registered. No glitch on state transitions.

Test Plan:
- Reset, then start, then words 0x00500093 (last=0) and 0x00A00113 (last=1):
  - Byte writes to addr 0..7 with data 93,00,50,00,13,01,A0,00.
  - done=1 and core_hold=0 five cycles after the second accept; word_count=2; truncated=0.
- After that load, drive fetch_addr=4 -> mem_addr=4 and mem_we=0.
- MEM_BYTES=16, four words, none with last:
  - DONE after the 4th word, truncated=1, word_count=4.
  - in_ready stays 0 while a 5th in_valid is held.
- Same config, 4th word with last=1 -> DONE with truncated=0.
- Reset asserted at WRITE byte 1 of the first word:
  - Next cycle mem_we=0, state IDLE, core_hold=1, word_count=0.
  - No further writes until a new start.
- From DONE, start plus one word 0xDEADBEEF (last=1):
  - Writes EF,BE,AD,DE to addr 0..3 with core_hold=1 during the load.
  - word_count=1, then done=1.
  - A start pulsed during WRITE has no effect.
